dm_cache_ctrl: RTL

- Parametrised direct-mapped, write-back, write-allocate cache with a full miss engine.
- Sits between a core-side load/store port and the memory arbiter.
- Handles one outstanding request at a time: tag check, dirty-line writeback, line fill, then response.
- Adds valid/dirty tracking, a memory handshake and hit/miss statistics.

---
 rtl/dm_cache_pkg.sv | 33 +++
 rtl/dm_cache_array.sv | 81 ++++++++
 rtl/dm_cache_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_pkg.sv
// Shared types and width helpers for the direct-mapped cache controller.
package dm_cache_pkg;

  // Controller FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    RESPOND   = 3'd4
  } cache_state_e;

  // Tag bits left over after removing index and offset from a word address.
  function automatic int tag_bits(input int width, input int logdepth, input int loglinesize);
    return width - logdepth - loglinesize;
  endfunction

  // LSB position of the index field within a word address.
  function automatic int index_lsb(input int loglinesize);
    return loglinesize;
  endfunction

  // LSB position of the tag field within a word address.
  function automatic int tag_lsb(input int logdepth, input int loglinesize);
    return logdepth + loglinesize;
  endfunction

  // Bits in one cache line.
  function automatic int line_bits(input int width, input int loglinesize);
    return width << loglinesize;
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Tag/valid/dirty/data storage: one registered read port, one write port.
// Every write installs a valid line; valid and dirty bits clear on reset.
module dm_cache_array
  import dm_cache_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int LOGDEPTH    = 9,
  parameter int LOGLINESIZE = 3
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            rd_en,
  input  logic [LOGDEPTH-1:0]                             rd_idx,
  output logic [tag_bits(WIDTH, LOGDEPTH, LOGLINESIZE)-1:0] rd_tag,
  output logic                                            rd_valid,
  output logic                                            rd_dirty,
  output logic [line_bits(WIDTH, LOGLINESIZE)-1:0]        rd_data,
  input  logic                                            wr_en,
  input  logic [LOGDEPTH-1:0]                             wr_idx,
  input  logic [tag_bits(WIDTH, LOGDEPTH, LOGLINESIZE)-1:0] wr_tag,
  input  logic                                            wr_dirty,
  input  logic [line_bits(WIDTH, LOGLINESIZE)-1:0]        wr_data
);

  localparam int TAGW  = tag_bits(WIDTH, LOGDEPTH, LOGLINESIZE);
  localparam int LINEW = line_bits(WIDTH, LOGLINESIZE);
  localparam int DEPTH = 1 << LOGDEPTH;

  logic [TAGW-1:0]  tag_mem  [DEPTH];
  logic [LINEW-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] dirty_q, dirty_d;
  logic [TAGW-1:0]  rd_tag_q;
  logic [LINEW-1:0] rd_data_q;
  logic             rd_valid_q, rd_dirty_q;

  // Next state of the per-line status bits.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      dirty_d[wr_idx] = wr_dirty;
    end
  end

  // Status bits and their registered read copies, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_dirty_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      if (rd_en) begin
        rd_valid_q <= valid_q[rd_idx];
        rd_dirty_q <= dirty_q[rd_idx];
      end
    end
  end

  // Tag and data arrays: plain memories, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_tag_q  <= tag_mem[rd_idx];
      rd_data_q <= data_mem[rd_idx];
    end
  end

  assign rd_tag   = rd_tag_q;
  assign rd_valid = rd_valid_q;
  assign rd_dirty = rd_dirty_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller with miss engine.
// Handshakes: a core request transfers on req_valid && req_ready (ready only
// in IDLE); resp_valid is a single-cycle completion pulse; mem_req is held
// with stable mem_we/mem_addr/mem_wdata until the cycle mem_ack is seen, and
// mem_ack is only looked at while mem_req is high.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int LOGDEPTH    = 9,
  parameter int LOGLINESIZE = 3,
  parameter int CNTWIDTH    = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [WIDTH-1:0]                  req_addr,
  input  logic [WIDTH-1:0]                  req_wdata,
  output logic                              resp_valid,
  output logic [WIDTH-1:0]                  resp_rdata,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [WIDTH-1:0]                  mem_addr,
  output logic [(WIDTH<<LOGLINESIZE)-1:0]   mem_wdata,
  input  logic                              mem_ack,
  input  logic [(WIDTH<<LOGLINESIZE)-1:0]   mem_rdata,
  output logic [CNTWIDTH-1:0]               hit_count,
  output logic [CNTWIDTH-1:0]               miss_count
);

  localparam int TAGW  = tag_bits(WIDTH, LOGDEPTH, LOGLINESIZE);
  localparam int LINEW = line_bits(WIDTH, LOGLINESIZE);
  localparam int IDXL  = index_lsb(LOGLINESIZE);
  localparam int TAGL  = tag_lsb(LOGDEPTH, LOGLINESIZE);
  localparam logic [CNTWIDTH-1:0] CNT_ONE = CNTWIDTH'(1);

  cache_state_e          state_q, state_d;
  logic                  req_we_q, req_we_d;
  logic [WIDTH-1:0]      req_addr_q, req_addr_d;
  logic [WIDTH-1:0]      req_wdata_q, req_wdata_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic [LINEW-1:0]      mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0]      resp_rdata_q, resp_rdata_d;
  logic [CNTWIDTH-1:0]   hit_count_q, hit_count_d;
  logic [CNTWIDTH-1:0]   miss_count_q, miss_count_d;

  logic                  rd_en, wr_en, wr_dirty;
  logic [LOGDEPTH-1:0]   wr_idx;
  logic [TAGW-1:0]       wr_tag;
  logic [LINEW-1:0]      wr_data;
  logic [TAGW-1:0]       rd_tag;
  logic                  rd_valid, rd_dirty;
  logic [LINEW-1:0]      rd_data;

  logic [LOGLINESIZE-1:0] req_off;
  logic [LOGDEPTH-1:0]    req_idx;
  logic [TAGW-1:0]        req_tag;
  logic                   hit;
  logic [WIDTH-1:0]       hit_word, fill_word;
  logic [LINEW-1:0]       merged_line, fill_line;

  assign req_off = req_addr_q[LOGLINESIZE-1:0];
  assign req_idx = req_addr_q[IDXL +: LOGDEPTH];
  assign req_tag = req_addr_q[TAGL +: TAGW];
  assign hit     = rd_valid && (rd_tag == req_tag);

  // Word selection and store merge for hit and fill lines.
  always_comb begin
    hit_word    = rd_data[req_off*WIDTH +: WIDTH];
    fill_word   = mem_rdata[req_off*WIDTH +: WIDTH];
    merged_line = rd_data;
    merged_line[req_off*WIDTH +: WIDTH] = req_wdata_q;
    fill_line   = mem_rdata;
    if (req_we_q) fill_line[req_off*WIDTH +: WIDTH] = req_wdata_q;
  end

  // FSM next state, array access, memory handshake and response outputs.
  always_comb begin
    state_d      = state_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = req_idx;
    wr_tag       = req_tag;
    wr_dirty     = 1'b0;
    wr_data      = merged_line;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_we_d    = req_we;
          req_addr_d  = req_addr;
          req_wdata_d = req_wdata;
          rd_en       = 1'b1;
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = req_we_q ? req_wdata_q : hit_word;
          if (req_we_q) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
          end
          if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_ONE;
          state_d = IDLE;
        end else if (rd_valid && rd_dirty) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {rd_tag, req_idx, {LOGLINESIZE{1'b0}}};
          mem_wdata_d = rd_data;
          state_d     = WRITEBACK;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_idx, {LOGLINESIZE{1'b0}}};
          state_d    = FILL;
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          // Victim is now clean in memory; keep it resident until the fill lands.
          wr_en      = 1'b1;
          wr_tag     = rd_tag;
          wr_data    = rd_data;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_idx, {LOGLINESIZE{1'b0}}};
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          wr_en        = 1'b1;
          wr_dirty     = req_we_q;
          wr_data      = fill_line;
          mem_req_d    = 1'b0;
          resp_rdata_d = req_we_q ? req_wdata_q : fill_word;
          state_d      = RESPOND;
        end
      end
      RESPOND: begin
        resp_valid = 1'b1;
        resp_rdata = resp_rdata_q;
        if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_ONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  dm_cache_array #(
    .WIDTH       (WIDTH),
    .LOGDEPTH    (LOGDEPTH),
    .LOGLINESIZE (LOGLINESIZE)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_idx   (req_addr[IDXL +: LOGDEPTH]),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_data  (rd_data),
    .wr_en    (wr_en && !reset),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr_dirty (wr_dirty),
    .wr_data  (wr_data)
  );

  assign req_ready  = (state_q == IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
